// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator datapath and its operand buffer.
package acc_pkg;

    localparam int ACC_WIDTH      = 4;
    localparam int ACC_FIFO_DEPTH = 4;

    typedef logic [ACC_WIDTH-1:0] acc_operand_t;

endpackage

// File: rtl/acc_operand_fifo_if.sv
// Producer/consumer-side bundle of the operand buffer. The producer drives
// pushes, hold and flush; the buffer returns the operand and its status.
interface acc_operand_fifo_if
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_FIFO_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             hold;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             drop;

    modport master (
        output wr_en, wr_data, hold, flush,
        input  d, count, empty, full, drop
    );

    modport slave (
        input  wr_en, wr_data, hold, flush,
        output d, count, empty, full, drop
    );

endinterface

// File: rtl/acc_operand_fifo.sv
// Operand buffer feeding the enable-less running-sum accumulator. Delivers one
// stored operand per clock on d and drives zero when idle, held or flushed, so
// the accumulator keeps its sum whenever nothing is delivered.
module acc_operand_fifo
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = ACC_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    acc_operand_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             drop_q, drop_d;

    logic             pop;
    logic             accept;

    // Pop/accept decode from pre-edge state; a full buffer still accepts a
    // push when it frees a slot on the same edge. No write-to-read bypass.
    always_comb begin
        pop    = !bus.hold && !bus.flush && (count_q != '0);
        accept = bus.wr_en && !bus.flush && ((count_q < CW'(DEPTH)) || pop);
    end

    // Next-state for pointers, fill level, outgoing operand and drop flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        d_d      = '0;
        drop_d   = drop_q;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (pop) begin
                d_d      = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (bus.wr_en && !accept) begin
                drop_d = 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset clears everything except storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            d_q      <= '0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            d_q      <= d_d;
            drop_q   <= drop_d;
        end
    end

    // Storage is deliberately left out of reset; only accepted pushes write it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.d     = d_q;
    assign bus.count = count_q;
    assign bus.empty = (count_q == '0);
    assign bus.full  = (count_q == CW'(DEPTH));
    assign bus.drop  = drop_q;

endmodule

// File: tb/tb_acc_operand_fifo.sv
// Bench for the accumulator operand buffer: directed scenarios followed by
// random traffic, all checked against a queue-based reference.
module tb_acc_operand_fifo;
    import acc_pkg::*;

    localparam int DEPTH = ACC_FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc_operand_fifo_if #(.WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) bus ();

    acc_operand_fifo #(.WIDTH(ACC_WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: stored operands in arrival order, last delivered value.
    acc_operand_t mq[$];
    acc_operand_t m_d;
    bit           m_drop;
    bit           m_popped;

    // Accumulator stand-in: samples d on the falling edge, wraps mod 16.
    acc_operand_t acc_sum = '0;
    bit           acc_clr = 1'b0;
    bit           acc_log = 1'b0;
    acc_operand_t acc_hist[$];

    bit           log_out = 1'b0;
    acc_operand_t out_seen[$];

    always @(negedge clk) begin
        if (acc_clr) acc_sum = '0;
        else         acc_sum = acc_sum + bus.d;
        if (acc_log) acc_hist.push_back(acc_sum);
    end

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_d      = '0;
        m_drop   = 1'b0;
        m_popped = 1'b0;
    endtask

    task automatic model_edge(bit we, acc_operand_t wd, bit h, bit f);
        bit do_pop;
        bit do_acc;
        m_popped = 1'b0;
        if (f) begin
            mq.delete();
            m_d    = '0;
            m_drop = 1'b0;
            return;
        end
        do_pop = !h && (mq.size() != 0);
        do_acc = we && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) begin
            m_d      = mq.pop_front();
            m_popped = 1'b1;
        end else begin
            m_d = '0;
        end
        if (do_acc) mq.push_back(wd);
        if (we && !do_acc) m_drop = 1'b1;
    endtask

    task automatic step(bit we, acc_operand_t wd, bit h, bit f);
        @(negedge clk);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.hold    = h;
        bus.flush   = f;
        @(posedge clk);
        model_edge(we, wd, h, f);
        #1;
        check_val("d",     32'(bus.d),     32'(m_d));
        check_val("count", 32'(bus.count), 32'(mq.size()));
        check_val("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check_val("full",  32'(bus.full),  32'(mq.size() == DEPTH));
        check_val("drop",  32'(bus.drop),  32'(m_drop));
        if (log_out && m_popped) out_seen.push_back(bus.d);
    endtask

    initial begin
        acc_operand_t vals[15];
        acc_operand_t seq[$];
        int           idx;
        int           cyc;
        bit           h;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.hold    = 1'b0;
        bus.flush   = 1'b0;
        model_reset();
        #1;
        check_val("rst_d",     32'(bus.d),     0);
        check_val("rst_count", 32'(bus.count), 0);
        check_val("rst_empty", 32'(bus.empty), 1);
        check_val("rst_full",  32'(bus.full),  0);
        check_val("rst_drop",  32'(bus.drop),  0);
        #6;
        rst = 1'b0;

        // Async reset between edges with a live operand on d.
        step(1, 4'd3, 1, 0);
        step(1, 4'd6, 1, 0);
        step(1, 4'd9, 1, 0);
        step(0, 4'd0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_d",     32'(bus.d),     0);
        check_val("arst_count", 32'(bus.count), 0);
        check_val("arst_empty", 32'(bus.empty), 1);
        check_val("arst_full",  32'(bus.full),  0);
        check_val("arst_drop",  32'(bus.drop),  0);
        rst = 1'b0;
        model_reset();

        // Streaming into a cleared accumulator.
        acc_clr = 1'b1;
        acc_log = 1'b1;
        step(1, 4'd5, 0, 0);
        acc_clr = 1'b0;
        step(1, 4'd5, 0, 0);
        step(1, 4'd4, 0, 0);
        step(1, 4'd6, 0, 0);
        step(0, 4'd0, 0, 0);
        step(0, 4'd0, 0, 0);
        acc_log = 1'b0;
        check_val("acc_len", 32'(acc_hist.size()), 6);
        if (acc_hist.size() == 6) begin
            check_val("acc_sum0", 32'(acc_hist[2]), 5);
            check_val("acc_sum1", 32'(acc_hist[3]), 10);
            check_val("acc_sum2", 32'(acc_hist[4]), 14);
            check_val("acc_sum3", 32'(acc_hist[5]), 4);
        end

        // Back-pressure: fill under hold, overflow push, then drain.
        for (int i = 1; i <= 4; i++) step(1, acc_operand_t'(i), 1, 0);
        check_val("bp_full", 32'(bus.full), 1);
        step(1, 4'd7, 1, 0);
        check_val("bp_drop", 32'(bus.drop), 1);
        for (int i = 0; i < 5; i++) step(0, 4'd0, 0, 0);
        check_val("bp_empty", 32'(bus.empty), 1);

        // Full plus pop on the same edge.
        step(0, 4'd0, 0, 1);
        for (int i = 11; i <= 14; i++) step(1, acc_operand_t'(i), 1, 0);
        step(1, 4'd9, 0, 0);
        check_val("fp_count", 32'(bus.count), 4);
        check_val("fp_drop",  32'(bus.drop),  0);
        for (int i = 0; i < 5; i++) step(0, 4'd0, 0, 0);

        // Flush beats a concurrent push and clears drop.
        for (int i = 1; i <= 5; i++) step(1, acc_operand_t'(i), 1, 0);
        step(0, 4'd0, 0, 0);
        check_val("fl_pre_count", 32'(bus.count), 3);
        step(1, 4'd8, 0, 1);
        check_val("fl_count", 32'(bus.count), 0);
        check_val("fl_drop",  32'(bus.drop),  0);
        for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 0);

        // Wrap-around: 10 distinct nonzero operands, hold toggling every 3 cycles.
        for (int i = 0; i < 15; i++) vals[i] = acc_operand_t'(i + 1);
        for (int i = 14; i > 0; i--) begin
            int j;
            acc_operand_t t;
            j       = int'($urandom_range(i, 0));
            t       = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        seq.delete();
        out_seen.delete();
        log_out = 1'b1;
        idx     = 0;
        cyc     = 0;
        while ((idx < 10 || mq.size() != 0) && cyc < 100) begin
            h = ((cyc / 3) % 2) == 0;
            if (idx < 10 && (mq.size() < DEPTH || !h)) begin
                seq.push_back(vals[idx]);
                step(1, vals[idx], h, 0);
                idx++;
            end else begin
                step(0, 4'd0, h, 0);
            end
            cyc++;
        end
        step(0, 4'd0, 0, 0);
        log_out = 1'b0;
        check_val("wrap_drop", 32'(bus.drop), 0);
        check_val("wrap_len",  32'(out_seen.size()), 10);
        if (out_seen.size() == 10 && seq.size() == 10) begin
            for (int i = 0; i < 10; i++) check_val("wrap_order", 32'(out_seen[i]), 32'(seq[i]));
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(1, 0)),
                 acc_operand_t'($urandom_range(15, 0)),
                 ($urandom_range(3, 0) == 0),
                 ($urandom_range(15, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
